// File: rtl/audio_onset_detector.sv
// rtl/audio_onset_detector.sv - rectify the codec sample stream, follow its envelope and report one peak per strike
module audio_onset_detector #(
    parameter int DECAY_SHIFT     = 6,
    parameter int PEAK_SAMPLES    = 32,
    parameter int HOLDOFF_SAMPLES = 4800
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        advance,
    input  logic [23:0] adc_left,
    input  logic [23:0] adc_right,
    input  logic [23:0] threshold,
    input  logic        hit_ack,
    input  logic        overrun_clr,
    output logic        hit_valid,
    output logic [23:0] hit_peak,
    output logic [23:0] envelope,
    output logic        overrun
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEAK,
        ST_HOLDOFF
    } state_t;

    localparam logic [15:0] PEAK_LAST = 16'(PEAK_SAMPLES - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF_SAMPLES - 1);

    // Full-scale negative has no positive twin in 24 bits, so it clamps.
    function automatic logic [23:0] abs_sat(input logic [23:0] x);
        if (!x[23]) begin
            return x;
        end else if (x == 24'h800000) begin
            return 24'h7FFFFF;
        end else begin
            return ~x + 24'd1;
        end
    endfunction

    logic        adv1_q, adv2_q, adv3_q;
    logic [23:0] left_q, right_q;
    logic [23:0] abs_l, abs_r;
    logic [23:0] mono_q;
    logic [23:0] env_q, env_d;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [23:0] peak_q, peak_d, peak_max;
    logic        valid_q, valid_d;
    logic [23:0] hit_peak_q, hit_peak_d;
    logic        overrun_q, overrun_d;
    logic        report;

    always_comb begin
        abs_l = abs_sat(left_q);
        abs_r = abs_sat(right_q);
    end

    always_comb begin
        env_d = env_q;
        if (adv2_q) begin
            if (mono_q > env_q) begin
                env_d = mono_q;
            end else begin
                env_d = env_q - (env_q >> DECAY_SHIFT);
            end
        end
    end

    always_comb begin
        peak_max = (env_q > peak_q) ? env_q : peak_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        peak_d     = peak_q;
        valid_d    = valid_q;
        hit_peak_d = hit_peak_q;
        overrun_d  = overrun_q;
        report     = 1'b0;

        if (hit_ack) begin
            valid_d = 1'b0;
        end
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end

        if (adv3_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (threshold != 24'd0 && env_q >= threshold) begin
                        state_d = ST_PEAK;
                        peak_d  = env_q;
                        cnt_d   = 16'd0;
                    end
                end
                ST_PEAK: begin
                    peak_d = peak_max;
                    if (cnt_q == PEAK_LAST) begin
                        report  = 1'b1;
                        state_d = ST_HOLDOFF;
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_HOLDOFF: begin
                    // A zeroed threshold still lets the block settle back to idle.
                    if (cnt_q == HOLD_LAST) begin
                        if (threshold == 24'd0 || env_q < (threshold >> 1)) begin
                            state_d = ST_IDLE;
                            cnt_d   = 16'd0;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                end
            endcase
        end

        // Setting overrun is evaluated after the clear so a coincident set wins.
        if (report) begin
            if (!valid_q || hit_ack) begin
                valid_d    = 1'b1;
                hit_peak_d = peak_max;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            adv1_q     <= 1'b0;
            adv2_q     <= 1'b0;
            adv3_q     <= 1'b0;
            left_q     <= 24'd0;
            right_q    <= 24'd0;
            mono_q     <= 24'd0;
            env_q      <= 24'd0;
            state_q    <= ST_IDLE;
            cnt_q      <= 16'd0;
            peak_q     <= 24'd0;
            valid_q    <= 1'b0;
            hit_peak_q <= 24'd0;
            overrun_q  <= 1'b0;
        end else begin
            adv1_q <= advance;
            adv2_q <= adv1_q;
            adv3_q <= adv2_q;
            if (advance) begin
                left_q  <= adc_left;
                right_q <= adc_right;
            end
            if (adv1_q) begin
                mono_q <= (abs_l > abs_r) ? abs_l : abs_r;
            end
            env_q      <= env_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            peak_q     <= peak_d;
            valid_q    <= valid_d;
            hit_peak_q <= hit_peak_d;
            overrun_q  <= overrun_d;
        end
    end

    assign hit_valid = valid_q;
    assign hit_peak  = hit_peak_q;
    assign envelope  = env_q;
    assign overrun   = overrun_q;

endmodule
